hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Hazard and stall controller for the 5-stage forwarding pipeline. It produces the suspend/flush controls consumed by the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers, and the ID-stage operand-forwarding selects. Inputs are source/destination register info from ID, EXE, MEM and WB, the EXE branch resolution, and the data-memory busy flag. A small FSM sequences multi-cycle load-use stalls and memory-wait freezes.

Parameters:
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (legal 1..3)
CNT_W, 2, width of the internal stall counter (must hold LOAD_LAT)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
id_rR1_i  in  5  ID source register 1
id_rR2_i  in  5  ID source register 2
id_re1_i  in  1  ID instruction reads rR1
id_re2_i  in  1  ID instruction reads rR2
exe_wr_i  in  5  EXE destination register
exe_we_i  in  1  EXE writes regfile
exe_is_load_i  in  1  EXE instruction is a load
mem_wr_i  in  5  MEM destination register
mem_we_i  in  1  MEM writes regfile
wb_wr_i  in  5  WB destination register
wb_we_i  in  1  WB writes regfile
exe_branch_taken_i  in  1  branch/jump resolved taken in EXE
mem_busy_i  in  1  data memory not ready, freeze pipeline
fwd_a_sel_o  out  2  rR1 source: 00 regfile, 01 EXE, 10 MEM, 11 WB
fwd_b_sel_o  out  2  rR2 source, same encoding
pc_suspend_o  out  1  hold PC
if_id_suspend_o  out  1  hold IF/ID
if_id_flush_o  out  1  clear IF/ID
id_exe_suspend_o  out  1  hold ID/EXE
id_exe_flush_o  out  1  insert bubble in ID/EXE
exe_mem_suspend_o  out  1  hold EXE/MEM

Behaviour:
- Reset: state RUN, counter 0, saved state RUN. While rst_i is high, all outputs are 0.
- Outputs are combinational from state plus current inputs. The same-cycle response drives the register inputs for the next edge.
- Forwarding (per source, priority order):
  - rR==0 or read-enable low -> 00.
  - EXE match with exe_we_i and !exe_is_load_i -> 01.
  - MEM match with mem_we_i -> 10.
  - WB match with wb_we_i -> 11.
  - otherwise 00.
  - Forwarding is forced to 00 whenever id_exe_flush_o=1.
- lu_hit = exe_is_load_i & exe_we_i & exe_wr_i!=0 & ((id_re1_i & exe_wr_i==id_rR1_i) | (id_re2_i & exe_wr_i==id_rR2_i)).
- Per-cycle priority: mem_busy_i > exe_branch_taken_i > stall state/lu_hit.
- RUN state:
  - mem_busy_i: assert all four suspends; no flush. Save RUN, go to MEM_WAIT.
  - else branch taken: if_id_flush_o=1 and id_exe_flush_o=1 for that cycle; PC not suspended. Stay in RUN; lu_hit is ignored.
  - else lu_hit: pc_suspend_o=1, if_id_suspend_o=1, id_exe_flush_o=1. If LOAD_LAT>1, load counter with LOAD_LAT-1 and go to LU_STALL.
- LU_STALL state:
  - Drives the same three outputs as a load-use stall.
  - Counter decrements each cycle; return to RUN when it reaches 1.
  - mem_busy_i pre-empts: save LU_STALL, counter frozen, go to MEM_WAIT.
- MEM_WAIT state:
  - While mem_busy_i is high: all four suspends are 1 and all flushes are 0. A taken branch is not acted on.
  - First cycle with mem_busy_i low: return to the saved state and evaluate that state's rules the same cycle.
- exe_mem_suspend_o is asserted only for memory-wait freezes.
- Reset mid-stall: immediately back to RUN, counter cleared.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0]. Both reset to 0.
- stall_cnt_o increments each cycle pc_suspend_o=1.
- flush_cnt_o increments each cycle if_id_flush_o=1.
- Both counters wrap at 2^32.
- When undefined, these ports and registers are absent.

Test Plan:
- ID rR1=5, EXE wr=5 we=1 non-load, MEM wr=5 we=1 -> fwd_a_sel_o=01. Drop EXE we -> 10. rR1=0 -> 00.
- Load x3 in EXE, ID reads x3, LOAD_LAT=1 -> one cycle of pc_suspend/if_id_suspend/id_exe_flush = 1. Next cycle fwd_a_sel_o=10, no stall.
- LOAD_LAT=2, same hazard -> exactly 2 consecutive stall cycles, then RUN.
- exe_branch_taken_i=1 together with lu_hit=1 -> if_id_flush_o=1, id_exe_flush_o=1, pc_suspend_o=0.
- mem_busy_i high 3 cycles during LU_STALL (LOAD_LAT=3, first stall cycle done) -> 3 cycles of all-suspend. Then the remaining 2 stall cycles, then RUN.
- With HAZARD_PERF_CNT_EN: 2 stalls plus 1 branch -> stall_cnt_o=2, flush_cnt_o=1. Assert rst_i async mid-sequence -> counters 0 and outputs 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and stall controller for the 5-stage forwarding pipeline.
//
// Produces suspend/flush controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline
// registers and the ID-stage operand forwarding selects. A small FSM sequences
// multi-cycle load-use stalls and memory-wait freezes.
//
// Parameters:
//   LOAD_LAT  bubble cycles inserted per load-use hazard (1..3)
//   CNT_W     width of the internal stall counter (must hold LOAD_LAT)
//
// Ports:
//   clk_i, rst_i                clock (rising edge), async active-high reset
//   id_rR1_i/id_rR2_i           ID source registers, id_re1_i/id_re2_i read enables
//   exe_wr_i/exe_we_i           EXE destination and write enable, exe_is_load_i
//   mem_wr_i/mem_we_i           MEM destination and write enable
//   wb_wr_i/wb_we_i             WB destination and write enable
//   exe_branch_taken_i          branch/jump resolved taken in EXE
//   mem_busy_i                  data memory not ready, freeze pipeline
//   fwd_a_sel_o/fwd_b_sel_o     operand source: 00 regfile, 01 EXE, 10 MEM, 11 WB
//   pc_suspend_o, if_id_suspend_o, if_id_flush_o,
//   id_exe_suspend_o, id_exe_flush_o, exe_mem_suspend_o   pipeline register controls
//
// Optional feature (macro HAZARD_PERF_CNT_EN): adds stall_cnt_o / flush_cnt_o,
// 32-bit wrapping counts of cycles with pc_suspend_o and if_id_flush_o asserted.

module hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rR1_i,
  input  logic [4:0] id_rR2_i,
  input  logic       id_re1_i,
  input  logic       id_re2_i,
  input  logic [4:0] exe_wr_i,
  input  logic       exe_we_i,
  input  logic       exe_is_load_i,
  input  logic [4:0] mem_wr_i,
  input  logic       mem_we_i,
  input  logic [4:0] wb_wr_i,
  input  logic       wb_we_i,
  input  logic       exe_branch_taken_i,
  input  logic       mem_busy_i,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o,
  output logic       pc_suspend_o,
  output logic       if_id_suspend_o,
  output logic       if_id_flush_o,
  output logic       id_exe_suspend_o,
  output logic       id_exe_flush_o,
  output logic       exe_mem_suspend_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StLuStall = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  // Remaining bubbles after the one issued in the hazard-detection cycle.
  localparam logic [CNT_W-1:0] LuReload = CNT_W'(LOAD_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       saved_q, saved_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       eff_state;

  logic       lu_hit;
  logic [1:0] fwd_a_raw, fwd_b_raw;
  logic       pc_susp, ifid_susp, ifid_flush, idexe_susp, idexe_flush, exemem_susp;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rr,
    input logic       re,
    input logic [4:0] ewr,
    input logic       ewe,
    input logic       eld,
    input logic [4:0] mwr,
    input logic       mwe,
    input logic [4:0] wwr,
    input logic       wwe
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (re && (rr != 5'd0)) begin
      if (ewe && !eld && (ewr == rr)) begin
        sel = 2'b01;
      end else if (mwe && (mwr == rr)) begin
        sel = 2'b10;
      end else if (wwe && (wwr == rr)) begin
        sel = 2'b11;
      end
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_raw = fwd_sel(id_rR1_i, id_re1_i, exe_wr_i, exe_we_i, exe_is_load_i,
                        mem_wr_i, mem_we_i, wb_wr_i, wb_we_i);
    fwd_b_raw = fwd_sel(id_rR2_i, id_re2_i, exe_wr_i, exe_we_i, exe_is_load_i,
                        mem_wr_i, mem_we_i, wb_wr_i, wb_we_i);
  end

  assign lu_hit = exe_is_load_i && exe_we_i && (exe_wr_i != 5'd0) &&
                  ((id_re1_i && (exe_wr_i == id_rR1_i)) ||
                   (id_re2_i && (exe_wr_i == id_rR2_i)));

  // Leaving MEM_WAIT resumes the saved state and applies its rules in the same cycle.
  assign eff_state = (state_q == StMemWait) ? saved_q : state_q;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    cnt_d       = cnt_q;
    pc_susp     = 1'b0;
    ifid_susp   = 1'b0;
    ifid_flush  = 1'b0;
    idexe_susp  = 1'b0;
    idexe_flush = 1'b0;
    exemem_susp = 1'b0;

    if (mem_busy_i) begin
      // Full freeze; the stall counter is held so the load-use stall resumes intact.
      pc_susp     = 1'b1;
      ifid_susp   = 1'b1;
      idexe_susp  = 1'b1;
      exemem_susp = 1'b1;
      state_d     = StMemWait;
      if (state_q != StMemWait) begin
        saved_d = state_q;
      end
    end else begin
      state_d = eff_state;
      case (eff_state)
        StLuStall: begin
          if (exe_branch_taken_i) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            state_d     = StRun;
            cnt_d       = '0;
          end else begin
            pc_susp     = 1'b1;
            ifid_susp   = 1'b1;
            idexe_flush = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
              state_d = StRun;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: begin
          if (exe_branch_taken_i) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
          end else if (lu_hit) begin
            pc_susp     = 1'b1;
            ifid_susp   = 1'b1;
            idexe_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              cnt_d   = LuReload;
              state_d = StLuStall;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      saved_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs are held low while reset is asserted.
  assign pc_suspend_o      = pc_susp & ~rst_i;
  assign if_id_suspend_o   = ifid_susp & ~rst_i;
  assign if_id_flush_o     = ifid_flush & ~rst_i;
  assign id_exe_suspend_o  = idexe_susp & ~rst_i;
  assign id_exe_flush_o    = idexe_flush & ~rst_i;
  assign exe_mem_suspend_o = exemem_susp & ~rst_i;
  // A bubble entering ID/EXE carries no operands, so forwarding is disabled.
  assign fwd_a_sel_o = (rst_i || idexe_flush) ? 2'b00 : fwd_a_raw;
  assign fwd_b_sel_o = (rst_i || idexe_flush) ? 2'b00 : fwd_b_raw;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pc_suspend_o) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (if_id_flush_o) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT = 1, 2, 3) share one directed
// stimulus stream. A per-instance behavioural model predicts all outputs every
// cycle; hand-computed literal checks pin the key scenarios.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  logic       clk, rst;
  logic [4:0] id_r1, id_r2, exe_wr, mem_wr, wb_wr;
  logic       id_re1, id_re2, exe_we, exe_load, mem_we, wb_we, br, busy;

  logic [1:0] fwd_a[3], fwd_b[3];
  logic       pc_s[3], ifid_s[3], ifid_f[3], idexe_s[3], idexe_f[3], exemem_s[3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt[3], flush_cnt[3];
`endif

  int errors = 0;
  int checks = 0;

  // Model state: bubbles still owed after the current cycle, and expected counts.
  int          lu_left[3];
  logic [31:0] m_stall[3], m_flush[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl #(
      .LOAD_LAT(g + 1),
      .CNT_W   (2)
    ) u_dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .id_rR1_i          (id_r1),
      .id_rR2_i          (id_r2),
      .id_re1_i          (id_re1),
      .id_re2_i          (id_re2),
      .exe_wr_i          (exe_wr),
      .exe_we_i          (exe_we),
      .exe_is_load_i     (exe_load),
      .mem_wr_i          (mem_wr),
      .mem_we_i          (mem_we),
      .wb_wr_i           (wb_wr),
      .wb_we_i           (wb_we),
      .exe_branch_taken_i(br),
      .mem_busy_i        (busy),
      .fwd_a_sel_o       (fwd_a[g]),
      .fwd_b_sel_o       (fwd_b[g]),
      .pc_suspend_o      (pc_s[g]),
      .if_id_suspend_o   (ifid_s[g]),
      .if_id_flush_o     (ifid_f[g]),
      .id_exe_suspend_o  (idexe_s[g]),
      .id_exe_flush_o    (idexe_f[g]),
      .exe_mem_suspend_o (exemem_s[g])
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt_o       (stall_cnt[g]),
      .flush_cnt_o       (flush_cnt[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_vec(input int i);
    return {fwd_a[i], fwd_b[i], pc_s[i], ifid_s[i], ifid_f[i], idexe_s[i], idexe_f[i],
            exemem_s[i]};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic re);
    if (!re || r == 5'd0) return 2'b00;
    if (exe_we && !exe_load && exe_wr == r) return 2'b01;
    if (mem_we && mem_wr == r) return 2'b10;
    if (wb_we && wb_wr == r) return 2'b11;
    return 2'b00;
  endfunction

  // Per-cycle model comparison, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic       p, s, f1, f2, ms, hit;
      logic [1:0] fa, fb;
      logic [9:0] e;
      p = 0; s = 0; f1 = 0; f2 = 0; ms = 0;
      if (rst) begin
        lu_left[i] = 0;
        m_stall[i] = 0;
        m_flush[i] = 0;
        check($sformatf("model_rst_outs[%0d]", i), 32'(dut_vec(i)), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("model_rst_stall_cnt[%0d]", i), stall_cnt[i], 32'd0);
        check($sformatf("model_rst_flush_cnt[%0d]", i), flush_cnt[i], 32'd0);
`endif
      end else begin
        hit = exe_load && exe_we && exe_wr != 5'd0 &&
              ((id_re1 && exe_wr == id_r1) || (id_re2 && exe_wr == id_r2));
        if (busy) begin
          p = 1; s = 1; ms = 1;
        end else if (br) begin
          f1 = 1; f2 = 1;
          lu_left[i] = 0;
        end else if (lu_left[i] > 0) begin
          p = 1; f2 = 1;
          lu_left[i]--;
        end else if (hit) begin
          p = 1; f2 = 1;
          lu_left[i] = i;  // LOAD_LAT - 1
        end
        fa = f2 ? 2'b00 : m_fwd(id_r1, id_re1);
        fb = f2 ? 2'b00 : m_fwd(id_r2, id_re2);
        e  = {fa, fb, p, p, f1, s, f2, ms};
        check($sformatf("model_outs[%0d]", i), 32'(dut_vec(i)), 32'(e));
`ifdef HAZARD_PERF_CNT_EN
        check($sformatf("model_stall_cnt[%0d]", i), stall_cnt[i], m_stall[i]);
        check($sformatf("model_flush_cnt[%0d]", i), flush_cnt[i], m_flush[i]);
`endif
        if (p) m_stall[i] = m_stall[i] + 32'd1;
        if (f1) m_flush[i] = m_flush[i] + 32'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_r1 = 0; id_r2 = 0; id_re1 = 0; id_re2 = 0;
    exe_wr = 0; exe_we = 0; exe_load = 0;
    mem_wr = 0; mem_we = 0; wb_wr = 0; wb_we = 0;
    br = 0; busy = 0;
  endtask

  task automatic set_lu_hit();
    clr();
    exe_wr = 5'd3; exe_we = 1; exe_load = 1;
    id_r1 = 5'd3; id_re1 = 1;
  endtask

  task automatic set_after_load();
    clr();
    mem_wr = 5'd3; mem_we = 1;
    id_r1 = 5'd3; id_re1 = 1;
  endtask

  initial begin
    rst = 1;
    clr();
    step();
    @(negedge clk);
    check("rst_outs_dut0", 32'(dut_vec(0)), 32'd0);
    step();
    rst = 0;

    // Forwarding priority
    step(); clr();
    id_r1 = 5'd5; id_re1 = 1; exe_wr = 5'd5; exe_we = 1; mem_wr = 5'd5; mem_we = 1;
    @(negedge clk); check("fwd_a_exe", 32'(fwd_a[0]), 32'h1);
    step(); exe_we = 0;
    @(negedge clk); check("fwd_a_mem", 32'(fwd_a[0]), 32'h2);
    step(); id_r1 = 5'd0; id_r2 = 5'd7; id_re2 = 1; wb_wr = 5'd7; wb_we = 1;
    @(negedge clk);
    check("fwd_a_x0", 32'(fwd_a[0]), 32'h0);
    check("fwd_b_wb", 32'(fwd_b[0]), 32'h3);
    step(); clr();

    // Load-use hazard, all three latencies in parallel
    step(); set_lu_hit();
    @(negedge clk);
    check("lu_pc_susp", 32'(pc_s[0]), 32'h1);
    check("lu_ifid_susp", 32'(ifid_s[0]), 32'h1);
    check("lu_idexe_flush", 32'(idexe_f[0]), 32'h1);
    check("lu_fwd_forced0", 32'(fwd_a[0]), 32'h0);
    check("lu_no_exemem", 32'(exemem_s[0]), 32'h0);
    step(); set_after_load();
    @(negedge clk);
    check("lat1_released", 32'(pc_s[0]), 32'h0);
    check("lat1_fwd_mem", 32'(fwd_a[0]), 32'h2);
    check("lat2_stall2", 32'(pc_s[1]), 32'h1);
    check("lat3_stall2", 32'(pc_s[2]), 32'h1);
    step();
    @(negedge clk);
    check("lat2_released", 32'(pc_s[1]), 32'h0);
    check("lat3_stall3", 32'(pc_s[2]), 32'h1);
    step();
    @(negedge clk);
    check("lat3_released", 32'(pc_s[2]), 32'h0);

    // Branch taken overrides load-use
    step(); set_lu_hit(); br = 1;
    @(negedge clk);
    check("br_ifid_flush", 32'(ifid_f[0]), 32'h1);
    check("br_idexe_flush", 32'(idexe_f[0]), 32'h1);
    check("br_no_pc_susp", 32'(pc_s[0]), 32'h0);
    step(); clr();

    // Memory wait during a LOAD_LAT=3 stall
    step(); set_lu_hit();
    step(); set_after_load(); busy = 1;
    @(negedge clk);
    check("mw_exemem", 32'(exemem_s[2]), 32'h1);
    check("mw_pc", 32'(pc_s[2]), 32'h1);
    check("mw_no_flush", 32'(idexe_f[2]), 32'h0);
    step();
    step();
    @(negedge clk);
    check("mw_exemem_3rd", 32'(exemem_s[2]), 32'h1);
    step(); busy = 0;
    @(negedge clk);
    check("mw_resume_pc", 32'(pc_s[2]), 32'h1);
    check("mw_resume_exemem", 32'(exemem_s[2]), 32'h0);
    check("mw_resume_flush", 32'(idexe_f[2]), 32'h1);
    check("mw_lat1_fwd", 32'(fwd_a[0]), 32'h2);
    step();
    @(negedge clk);
    check("mw_last_stall", 32'(pc_s[2]), 32'h1);
    step();
    @(negedge clk);
    check("mw_released", 32'(pc_s[2]), 32'h0);

    // Busy masks a branch; branch acted on once busy drops
    step(); clr(); busy = 1; br = 1;
    @(negedge clk);
    check("busy_br_no_flush", 32'(ifid_f[0]), 32'h0);
    check("busy_br_pc", 32'(pc_s[0]), 32'h1);
    step(); busy = 0;
    @(negedge clk);
    check("after_busy_br_flush", 32'(ifid_f[0]), 32'h1);
    check("after_busy_br_pc", 32'(pc_s[0]), 32'h0);
    step(); clr();

    // Fresh reset, then 2 stalls + 1 branch on LOAD_LAT=1
    step(); rst = 1;
    step(); rst = 0;
    step(); set_lu_hit();
    step(); clr();
    step(); clr();
    step(); set_lu_hit();
    step(); clr();
    step(); br = 1;
    step(); clr();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_cnt", stall_cnt[0], 32'd2);
    check("perf_flush_cnt", flush_cnt[0], 32'd1);
`endif

    // Asynchronous reset in the middle of a stall cycle
    step(); set_lu_hit();
    #1;
    check("pre_rst_pc", 32'(pc_s[2]), 32'h1);
    rst = 1;
    #1;
    check("async_rst_outs0", 32'(dut_vec(0)), 32'd0);
    check("async_rst_outs2", 32'(dut_vec(2)), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("async_rst_stall_cnt", stall_cnt[0], 32'd0);
    check("async_rst_flush_cnt", flush_cnt[0], 32'd0);
`endif
    step(); rst = 0; clr();
    @(negedge clk);
    check("post_rst_no_stall", 32'(pc_s[2]), 32'h0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
